// File: rtl/line_fill_controller.sv
`default_nettype none
// ============================================================================
// line_fill_controller : critical-word-first cache line fill with write merge
// Revision 1.0
// ============================================================================
module line_fill_controller #(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_SIZE       = 512,
    parameter int NUM_SEGMENTS     = 16,
    parameter int NUM_SEGMENTS_LOG = 4,
    parameter int ADDR_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill_req,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic                  wr_en,
    input  logic [WORD_SIZE-1:0]  wr_data,
    output logic                  busy,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    output logic                  crit_valid,
    output logic [WORD_SIZE-1:0]  crit_word,
    output logic                  line_valid,
    output logic [BLOCK_SIZE-1:0] line_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                      r_state;
    logic [NUM_SEGMENTS_LOG-1:0] r_crit_off;
    logic [NUM_SEGMENTS_LOG-1:0] r_beat_cnt;
    logic                        r_wr_en;
    logic [WORD_SIZE-1:0]        r_wr_data;

    logic [NUM_SEGMENTS_LOG-1:0] w_word_idx;
    logic [WORD_SIZE-1:0]        w_beat_word;
    logic                        w_first_beat;
    logic                        w_last_beat;

    // Wrap-order placement: the counter width gives the modulo for free.
    assign w_word_idx   = r_crit_off + r_beat_cnt;
    assign w_first_beat = (r_beat_cnt == '0);
    assign w_last_beat  = (r_beat_cnt == NUM_SEGMENTS_LOG'(NUM_SEGMENTS - 1));
    assign w_beat_word  = (w_first_beat && r_wr_en) ? r_wr_data : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_crit_off <= '0;
            r_beat_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            crit_valid <= 1'b0;
            crit_word  <= '0;
            line_valid <= 1'b0;
            line_out   <= '0;
        end else begin
            crit_valid <= 1'b0;
            line_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (fill_req) begin
                        r_crit_off <= fill_addr[NUM_SEGMENTS_LOG+1:2];
                        r_beat_cnt <= '0;
                        r_wr_en    <= wr_en;
                        r_wr_data  <= wr_data;
                        mem_addr   <= fill_addr & ~ADDR_WIDTH'(3);
                        mem_req    <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (mem_rvalid) begin
                        for (int i = 0; i < NUM_SEGMENTS; i++) begin
                            if (w_word_idx == NUM_SEGMENTS_LOG'(i))
                                line_out[i*WORD_SIZE +: WORD_SIZE] <= w_beat_word;
                        end
                        // Write misses already own the critical word; only reads get it early.
                        if (w_first_beat && !r_wr_en) begin
                            crit_valid <= 1'b1;
                            crit_word  <= mem_rdata;
                        end
                        r_beat_cnt <= r_beat_cnt + NUM_SEGMENTS_LOG'(1);
                        if (w_last_beat) begin
                            line_valid <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/line_fill_controller.md
LINE_FILL_CONTROLLER -- requirements
Module: line_fill_controller

Interface
REQ-001 Parameter WORD_SIZE, default 32, SHALL set data word width in bits.
REQ-002 Parameter BLOCK_SIZE, default 512, SHALL set cache line width in bits.
REQ-003 Parameter NUM_SEGMENTS, default 16, SHALL set words per line (BLOCK_SIZE/WORD_SIZE).
REQ-004 Parameter NUM_SEGMENTS_LOG, default 4, SHALL equal log2(NUM_SEGMENTS).
REQ-005 Parameter ADDR_WIDTH, default 32, SHALL set byte address width.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 fill_req  input  1  start a line fill; sampled only in IDLE.
REQ-010 fill_addr  input  ADDR_WIDTH  byte address of the missing word; word offset = fill_addr[NUM_SEGMENTS_LOG+1:2].
REQ-011 wr_en  input  1  miss is a CPU write; sampled with fill_req.
REQ-012 wr_data  input  WORD_SIZE  CPU write word; sampled with fill_req.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 mem_req  output  1  memory read request, held until mem_ack.
REQ-015 mem_addr  output  ADDR_WIDTH  word-aligned critical-word address (fill_addr with bits[1:0]=0).
REQ-016 mem_ack  input  1  memory accepted request.
REQ-017 mem_rvalid  input  1  one returned beat on mem_rdata.
REQ-018 mem_rdata  input  WORD_SIZE  returned beat data.
REQ-019 crit_valid  output  1  one-cycle pulse: critical word available for a read miss.
REQ-020 crit_word  output  WORD_SIZE  critical word, valid while crit_valid.
REQ-021 line_valid  output  1  one-cycle pulse: line_out complete.
REQ-022 line_out  output  BLOCK_SIZE  assembled line; word i at bits [i*WORD_SIZE +: WORD_SIZE].

Function
REQ-023 FSM states SHALL be IDLE, REQ, FILL, DONE.
REQ-024 IDLE: fill_req=1 -> latch fill_addr, wr_en, wr_data, crit offset; beat counter=0; next REQ.
REQ-025 REQ: mem_req=1, mem_addr stable; mem_ack=1 in same cycle -> next FILL, mem_req low the following cycle.
REQ-026 Memory returns NUM_SEGMENTS beats in wrap order; beat n SHALL be stored at word index (crit_off + n) mod NUM_SEGMENTS (4-bit wrap).
REQ-027 Beat 0 with latched wr_en=1 SHALL store latched wr_data instead of mem_rdata (write-allocate merge); other beats store mem_rdata.
REQ-028 Beat 0 with latched wr_en=0 SHALL assert crit_valid in the cycle after mem_rvalid, crit_word=that mem_rdata; no crit_valid for write misses.
REQ-029 Beat counter increments only on mem_rvalid in FILL; gaps between beats allowed, no timeout.
REQ-030 Beat NUM_SEGMENTS-1 accepted -> next DONE.
REQ-031 DONE: line_valid=1 for exactly one cycle, then IDLE; busy deasserts in the cycle line_valid is high? No: busy=1 in DONE, 0 the cycle after.
REQ-032 line_out SHALL hold its value from DONE until the next fill is accepted; words are updated in place during FILL.
REQ-033 fill_req while busy SHALL be ignored (no queuing); requester must hold/retry.
REQ-034 mem_rvalid in IDLE, REQ or DONE SHALL be ignored.
REQ-035 mem_ack outside REQ SHALL be ignored.
REQ-036 Latency from fill_req to line_valid with mem_ack immediate and back-to-back beats: 1 (REQ) + 16 beats + 1 (DONE) cycles minimum.

Reset
REQ-037 rst_n=0 SHALL immediately force IDLE, busy=0, mem_req=0, mem_addr=0, crit_valid=0, crit_word=0, line_valid=0, line_out=0, beat counter=0.
REQ-038 Reset mid-fill SHALL abandon the line; no line_valid; subsequent stray mem_rvalid ignored in IDLE.

Verification
REQ-039 Read miss, fill_addr=0x0000_1008 (offset 2), ack immediate, beats 0xA0..0xAF -> mem_addr=0x1008, crit_valid once with 0xA0, line word2=0xA0, word15=0xAD, word0=0xAE, word1=0xAF, line_valid one cycle.
REQ-040 Write miss offset 15, wr_data=0xDEADBEEF, beats 0x00..0x0F -> no crit_valid, word15=0xDEADBEEF, word0=0x01, word14=0x0F.
REQ-041 mem_ack delayed 5 cycles, beats with random 0-3 cycle gaps -> mem_req held 6 cycles, line identical to gap-free run.
REQ-042 fill_req pulsed during FILL -> ignored, single line_valid; next fill_req after IDLE accepted.
REQ-043 rst_n asserted after beat 7 -> all outputs zero immediately; remaining beats ignored; new fill completes correctly.
REQ-044 mem_rvalid pulses in IDLE -> line_out unchanged, no pulses.
